// File: rtl/playseq_controle_rodadas.sv
// playseq_controle_rodadas: incremental-round controller for PlaySeq.
// Round r previews RAM positions 0..r on the LED, then the player repeats them.
// Optional feature: define PLAYSEQ_VIDAS_EN to enable the lives counter.
// Ports:
//   clock, reset        : system clock (rising edge), async active-high reset
//   jogar               : start/restart request (level, INICIAL and FIM_*)
//   limite [AW]         : index of the last round, sampled in PREPARA
//   tem_jogada          : one-cycle button pulse
//   igual               : play register matches RAM[endereco], used in COMPARA
//   endereco, rodada    : RAM address and current round index
//   vidas [3]           : remaining lives (0 when lives are disabled)
//   mostra_led, registraR : LED enable and play-register load strobes
//   pronto, ganhou, perdeu, deu_timeout : end-of-game flags
//   db_estado [4]       : state code
module playseq_controle_rodadas #(
  parameter int DEPTH          = 16,
  parameter int LED_CYCLES     = 1000,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int LIVES          = 3,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          jogar,
  input  logic [AW-1:0] limite,
  input  logic          tem_jogada,
  input  logic          igual,
  output logic [AW-1:0] endereco,
  output logic [AW-1:0] rodada,
  output logic [2:0]    vidas,
  output logic          mostra_led,
  output logic          registraR,
  output logic          pronto,
  output logic          ganhou,
  output logic          perdeu,
  output logic          deu_timeout,
  output logic [3:0]    db_estado
);

  localparam int MAXC = (LED_CYCLES > TIMEOUT_CYCLES) ? LED_CYCLES : TIMEOUT_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [TW-1:0] LED_LAST = TW'(LED_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    MOSTRA      = 4'h2,
    INTERVALO   = 4'h3,
    ESPERA      = 4'h4,
    REGISTRA    = 4'h5,
    COMPARA     = 4'h6,
    PROXIMO     = 4'h7,
    NOVA_RODADA = 4'h8,
    PERDE_VIDA  = 4'h9,
    FIM_ACERTO  = 4'hA,
    FIM_ERRO    = 4'hE,
    FIM_TIMEOUT = 4'hF
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] endereco_r, endereco_n;
  logic [AW-1:0] rodada_r, rodada_n;
  logic [AW-1:0] limite_r, limite_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    vidas_r, vidas_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= INICIAL;
      endereco_r <= '0;
      rodada_r   <= '0;
      limite_r   <= '0;
      timer      <= '0;
      vidas_r    <= '0;
    end else begin
      state      <= state_n;
      endereco_r <= endereco_n;
      rodada_r   <= rodada_n;
      limite_r   <= limite_n;
      timer      <= timer_n;
      vidas_r    <= vidas_n;
    end
  end

  always_comb begin
    state_n    = state;
    endereco_n = endereco_r;
    rodada_n   = rodada_r;
    limite_n   = limite_r;
    timer_n    = timer;
    vidas_n    = vidas_r;
    case (state)
      INICIAL: if (jogar) state_n = PREPARA;
      PREPARA: begin
        limite_n   = limite;
        endereco_n = '0;
        rodada_n   = '0;
`ifdef PLAYSEQ_VIDAS_EN
        vidas_n    = 3'(LIVES);
`else
        vidas_n    = '0;
`endif
        timer_n    = '0;
        state_n    = MOSTRA;
      end
      MOSTRA: begin
        if (timer == LED_LAST) begin
          timer_n = '0;
          state_n = INTERVALO;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      INTERVALO: begin
        if (timer == LED_LAST) begin
          timer_n = '0;
          if (endereco_r == rodada_r) begin
            endereco_n = '0;
            state_n    = ESPERA;
          end else begin
            endereco_n = endereco_r + 1'b1;
            state_n    = MOSTRA;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      ESPERA: begin
        // a press on the terminal-count cycle still counts as a move
        if (tem_jogada) begin
          timer_n = '0;
          state_n = REGISTRA;
        end else if (timer == TO_LAST) begin
          timer_n = '0;
          state_n = FIM_TIMEOUT;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      REGISTRA: state_n = COMPARA;
      COMPARA: begin
        if (igual) begin
          if (endereco_r < rodada_r)      state_n = PROXIMO;
          else if (rodada_r < limite_r)   state_n = NOVA_RODADA;
          else                            state_n = FIM_ACERTO;
        end else begin
`ifdef PLAYSEQ_VIDAS_EN
          state_n = (vidas_r > 3'd1) ? PERDE_VIDA : FIM_ERRO;
`else
          state_n = FIM_ERRO;
`endif
        end
      end
      PROXIMO: begin
        endereco_n = endereco_r + 1'b1;
        state_n    = ESPERA;
      end
      NOVA_RODADA: begin
        rodada_n   = rodada_r + 1'b1;
        endereco_n = '0;
        state_n    = MOSTRA;
      end
      PERDE_VIDA: begin
`ifdef PLAYSEQ_VIDAS_EN
        vidas_n    = vidas_r - 3'd1;
`endif
        endereco_n = '0;
        state_n    = MOSTRA;
      end
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: if (jogar) state_n = PREPARA;
      default: state_n = INICIAL;
    endcase
  end

`ifndef PLAYSEQ_VIDAS_EN
  logic unused_lives;
  assign unused_lives = |LIVES;
`endif

  assign endereco    = endereco_r;
  assign rodada      = rodada_r;
  assign vidas       = vidas_r;
  assign mostra_led  = (state == MOSTRA);
  assign registraR   = (state == REGISTRA);
  assign pronto      = (state == FIM_ACERTO) || (state == FIM_ERRO) || (state == FIM_TIMEOUT);
  assign ganhou      = (state == FIM_ACERTO);
  assign perdeu      = (state == FIM_ERRO) || (state == FIM_TIMEOUT);
  assign deu_timeout = (state == FIM_TIMEOUT);
  assign db_estado   = state;

endmodule

// File: tb/tb_playseq_controle_rodadas.sv
// Directed bench for playseq_controle_rodadas with DEPTH=4, LED_CYCLES=3,
// TIMEOUT_CYCLES=10, LIVES=2. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_playseq_controle_rodadas;

  logic       clock = 1'b0;
  logic       reset;
  logic       jogar;
  logic [1:0] limite;
  logic       tem_jogada;
  logic       igual;
  logic [1:0] endereco;
  logic [1:0] rodada;
  logic [2:0] vidas;
  logic       mostra_led, registraR, pronto, ganhou, perdeu, deu_timeout;
  logic [3:0] db_estado;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

`ifdef PLAYSEQ_VIDAS_EN
  localparam logic [2:0] V_INI = 3'd2;
`else
  localparam logic [2:0] V_INI = 3'd0;
`endif

  playseq_controle_rodadas #(
    .DEPTH(4), .LED_CYCLES(3), .TIMEOUT_CYCLES(10), .LIVES(2)
  ) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .limite(limite),
    .tem_jogada(tem_jogada), .igual(igual), .endereco(endereco),
    .rodada(rodada), .vidas(vidas), .mostra_led(mostra_led),
    .registraR(registraR), .pronto(pronto), .ganhou(ganhou),
    .perdeu(perdeu), .deu_timeout(deu_timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ticks until db_estado reaches code; cycles = number of ticks taken.
  task automatic wait_state(input string tag, input logic [3:0] code, input int budget,
                            output int cycles);
    cycles = 0;
    while (db_estado !== code && cycles < budget) begin
      tick();
      cycles++;
    end
    chk(tag, {28'd0, db_estado}, {28'd0, code});
  endtask

  task automatic start(input logic [1:0] lim);
    jogar = 1'b1; limite = lim;
    tick();
    chk("prepara", {28'd0, db_estado}, 32'h1);
    jogar = 1'b0;
    tick();
    chk("mostra_entry", {28'd0, db_estado}, 32'h2);
  endtask

  // One move from ESPERA; returns at the cycle after COMPARA's decision.
  task automatic play(input logic g);
    tem_jogada = 1'b1; igual = g;
    tick();
    tem_jogada = 1'b0;
    chk("registraR", {31'd0, registraR}, 32'd1);
    tick();
    chk("compara", {28'd0, db_estado}, 32'h6);
    tick();
  endtask

  initial begin
    reset = 1'b1; jogar = 1'b0; limite = '0; tem_jogada = 1'b0; igual = 1'b0;
    #1;
    chk("rst_state", {28'd0, db_estado}, 32'h0);
    chk("rst_outs", {20'd0, endereco, rodada, vidas, mostra_led, registraR, pronto,
                     ganhou, perdeu, deu_timeout}, 32'd0);
    tick();
    reset = 1'b0;

    // Round 0 preview, exact LED on/off timing
    start(2'd1);
    chk("led_on0", {29'd0, mostra_led, endereco}, 32'h4);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("led_on", {29'd0, mostra_led, endereco}, 32'h4);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("led_off", {27'd0, mostra_led, db_estado}, 32'h3);
    end
    tick();
    chk("espera0", {28'd0, db_estado}, 32'h4);
    chk("vidas_ini", {29'd0, vidas}, {29'd0, V_INI});

    // Round 0 correct, then round 1 preview takes 12 cycles
    play(1'b1);
    chk("nova_rodada", {28'd0, db_estado}, 32'h8);
    tick();
    chk("round1", {26'd0, db_estado, rodada}, {26'd0, 4'h2, 2'd1});
    wait_state("preview1", 4'h4, 40, cyc);
    chk("preview1_len", cyc, 32'd12);
    play(1'b1);
    chk("proximo", {28'd0, db_estado}, 32'h7);
    tick();
    chk("espera_pos1", {26'd0, db_estado, endereco}, {26'd0, 4'h4, 2'd1});
    play(1'b1);
    chk("fim_acerto", {24'd0, db_estado, pronto, ganhou, perdeu, deu_timeout},
        {24'd0, 4'hA, 4'b1100});

    // Timeout after 10 idle ESPERA cycles; lives untouched
    start(2'd0);
    wait_state("preview0", 4'h4, 40, cyc);
    chk("preview0_len", cyc, 32'd6);
    repeat (9) tick();
    chk("espera_last", {28'd0, db_estado}, 32'h4);
    tick();
    chk("fim_timeout", {24'd0, db_estado, pronto, ganhou, perdeu, deu_timeout},
        {24'd0, 4'hF, 4'b1011});
    chk("timeout_vidas", {29'd0, vidas}, {29'd0, V_INI});

    // Press on the terminal-count cycle wins over the timeout
    start(2'd0);
    wait_state("espera_tc", 4'h4, 40, cyc);
    repeat (9) tick();
    tem_jogada = 1'b1; igual = 1'b1;
    tick();
    tem_jogada = 1'b0;
    chk("tc_registra", {28'd0, db_estado}, 32'h5);
    tick();
    tick();
    chk("tc_acerto", {28'd0, db_estado}, 32'hA);

    // Mismatch handling
    start(2'd1);
    wait_state("espera_err", 4'h4, 40, cyc);
    play(1'b0);
`ifdef PLAYSEQ_VIDAS_EN
    chk("perde_vida", {28'd0, db_estado}, 32'h9);
    tick();
    chk("replay", {24'd0, db_estado, mostra_led, endereco, rodada[0]}, {24'd0, 4'h2, 4'b1000});
    chk("vidas_dec", {29'd0, vidas}, 32'd1);
    wait_state("espera_err2", 4'h4, 40, cyc);
    chk("replay_len", cyc, 32'd6);
    play(1'b0);
`endif
    chk("fim_erro", {24'd0, db_estado, pronto, ganhou, perdeu, deu_timeout},
        {24'd0, 4'hE, 4'b1010});

    // Asynchronous reset during round 1 preview
    start(2'd1);
    wait_state("espera_rst", 4'h4, 40, cyc);
    play(1'b1);
    tick();
    repeat (6) tick();
    chk("pre_rst", {25'd0, db_estado, mostra_led, endereco}, {25'd0, 4'h2, 3'b101});
    reset = 1'b1;
    #1;
    chk("async_rst", {21'd0, db_estado, mostra_led, endereco, rodada, vidas}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("idle_after_rst", {28'd0, db_estado}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
